digit_scanner: RTL and testbench

- Time-multiplexes one 16-bit display group (four 4-bit digits) onto a 4-digit common-anode seven-segment display.
- Sits downstream of the group selector mux: it takes the selected 16-bit `group_out` value and splits it back into per-digit anode and segment drive, one digit at a time.
- The input group is snapshotted once per frame so a digit never shows a mix of old and new values.

---
 rtl/digit_scanner.sv | 125 ++++++++++++
 tb/tb_digit_scanner.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/digit_scanner.sv
// Four-digit common-anode seven-segment scanner with per-frame input snapshot.
// Optional DIGIT_SCANNER_ZERO_BLANK_EN enables leading-zero suppression.
module digit_scanner #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] group_in,
  input  logic        blank,
  input  logic [3:0]  dp_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam logic [19:0] TC = 20'(SCAN_DIV - 1);

  logic [19:0] div_cnt_q, div_cnt_d;
  logic [1:0]  dig_q, dig_d;
  logic [15:0] grp_q, grp_d;
  logic [3:0]  dp_q, dp_d;
  logic        first_q;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dpo_q, dpo_d;
  logic        fs_q, fs_d;

  logic       tc;
  logic       snap;
  logic       supp;
  logic       off;
  logic [3:0] nib;

  assign tc   = (div_cnt_q == TC);
  assign snap = first_q | (tc & (dig_q == 2'd3));
  assign nib  = grp_q[{dig_q, 2'b00} +: 4];

`ifdef DIGIT_SCANNER_ZERO_BLANK_EN
  // A digit is dark while it and everything left of it is zero
  always_comb begin
    supp = 1'b0;
    unique case (dig_q)
      2'd3:    supp = (grp_q[15:12] == 4'h0);
      2'd2:    supp = (grp_q[15:8] == 8'h00);
      2'd1:    supp = (grp_q[15:4] == 12'h000);
      default: supp = 1'b0;
    endcase
  end
`else
  assign supp = 1'b0;
`endif

  // The snapshot cycle after reset keeps the display dark and the count parked
  assign off = blank | tc | supp | first_q;

  always_comb begin
    div_cnt_d = div_cnt_q + 20'd1;
    dig_d     = dig_q;
    if (first_q) begin
      div_cnt_d = 20'd0;
    end else if (tc) begin
      div_cnt_d = 20'd0;
      dig_d     = dig_q + 2'd1;
    end
    grp_d = snap ? group_in : grp_q;
    dp_d  = snap ? dp_in : dp_q;
    fs_d  = snap;
    an_d  = off ? 4'b1111 : ~(4'b0001 << dig_q);
    dpo_d = off | ~dp_q[dig_q];
  end

  always_comb begin
    seg_d = 7'b1111111;
    unique case (nib)
      4'h0: seg_d = 7'b1000000;
      4'h1: seg_d = 7'b1111001;
      4'h2: seg_d = 7'b0100100;
      4'h3: seg_d = 7'b0110000;
      4'h4: seg_d = 7'b0011001;
      4'h5: seg_d = 7'b0010010;
      4'h6: seg_d = 7'b0000010;
      4'h7: seg_d = 7'b1111000;
      4'h8: seg_d = 7'b0000000;
      4'h9: seg_d = 7'b0010000;
      4'hA: seg_d = 7'b0001000;
      4'hB: seg_d = 7'b0000011;
      4'hC: seg_d = 7'b1000110;
      4'hD: seg_d = 7'b0100001;
      4'hE: seg_d = 7'b0000110;
      4'hF: seg_d = 7'b0001110;
    endcase
    if (first_q) seg_d = 7'b1111111;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= 20'd0;
      dig_q     <= 2'd0;
      grp_q     <= 16'h0000;
      dp_q      <= 4'h0;
      first_q   <= 1'b1;
      an_q      <= 4'b1111;
      seg_q     <= 7'b1111111;
      dpo_q     <= 1'b1;
      fs_q      <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      dig_q     <= dig_d;
      grp_q     <= grp_d;
      dp_q      <= dp_d;
      first_q   <= 1'b0;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dpo_q     <= dpo_d;
      fs_q      <= fs_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dpo_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_digit_scanner.sv
// Randomized self-checking bench for digit_scanner against a time-index model.
// Define DIGIT_SCANNER_ZERO_BLANK_EN for both files to check zero suppression.
module tb_digit_scanner;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] group_in = 16'h1234;
  logic        blank = 1'b0;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  digit_scanner #(.SCAN_DIV(S)) dut (
    .clk         (clk),
    .rst         (rst),
    .group_in    (group_in),
    .blank       (blank),
    .dp_in       (dp_in),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  logic [6:0] gly [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Model: n counts edges since reset release; display is a pure
  // function of n, the frame snapshot and the sampled blank.
  int          n = 0;
  logic        ready = 1'b0;
  logic [15:0] snap_g = '0;
  logic [3:0]  snap_dp = '0;
  logic [3:0]  e_an = 4'hF;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_dp = 1'b1;
  logic        e_fs = 1'b0;

  always @(posedge clk) begin
    int p, d, w;
    logic [3:0] nb;
    logic sup, of;
    ready = 1'b1;
    if (rst) begin
      n = 0;
      snap_g = '0;
      snap_dp = '0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
    end else begin
      n++;
      e_fs = ((n - 1) % (4 * S)) == 0;
      if (n < 2) begin
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
        p  = n - 2;
        d  = (p / S) % 4;
        w  = p % S;
        nb = 4'((snap_g >> (4 * d)) & 16'hF);
        sup = 1'b0;
`ifdef DIGIT_SCANNER_ZERO_BLANK_EN
        sup = (d > 0) && ((snap_g >> (4 * d)) == 16'h0);
`endif
        of = blank || (w == S - 1) || sup;
        e_seg = gly[nb];
        e_an  = of ? 4'hF : ~(4'(1) << d);
        e_dp  = of ? 1'b1 : ~snap_dp[d];
      end
      if (e_fs) begin
        snap_g  = group_in;
        snap_dp = dp_in;
      end
    end
  end

  always @(negedge clk) begin
    if (ready) begin
      chk("an", 16'(an), 16'(e_an));
      chk("seg", 16'(seg), 16'(e_seg));
      chk("dp", 16'(dp), 16'(e_dp));
      chk("frame_start", 16'(frame_start), 16'(e_fs));
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    cyc(5);
    rst = 1'b0;
    cyc(3 * 4 * S);
    cyc(2 * S + 1);
    group_in = 16'hABCD;
    cyc(3 * 4 * S);
    blank = 1'b1;
    cyc(10);
    blank = 1'b0;
    dp_in = 4'b0100;
    cyc(2 * 4 * S + 3);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(2 * 4 * S);
    group_in = 16'h0040;
    cyc(3 * 4 * S);
    for (int i = 0; i < 120; i++) begin
      group_in = 16'($urandom) >> ($urandom_range(0, 4) * 4);
      dp_in    = 4'($urandom);
      blank    = ($urandom_range(0, 7) == 0);
      rst      = ($urandom_range(0, 24) == 0);
      cyc(1);
      rst = 1'b0;
      cyc($urandom_range(1, 30));
    end
    blank = 1'b0;
    group_in = 16'h0040;
    cyc(3 * 4 * S);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
